donut_frame_streamer: RTL and testbench
=======================================

DONUT_FRAME_STREAMER -- requirements
Module: donut_frame_streamer

Interface
REQ-001 Parameter FRAME_PIXELS, default 70400, pixels per frame.
REQ-002 Parameter LINE_PIXELS, default 320, pixels per line; FRAME_PIXELS SHALL be a multiple of it.
REQ-003 Parameter NUM_FRAMES, default 30, frames stored in ROM.
REQ-004 Parameter FRAME_REPEAT, default 2, passes of each frame before advancing.
REQ-005 clk_i  in  1  the design has one clock.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 start_i  in  1  pulse; begin streaming.
REQ-008 stop_i  in  1  pulse; stop at the next frame boundary.
REQ-009 rom_cen_o  out  1  ROM read enable.
REQ-010 rom_addr_o  out  32  ROM read address.
REQ-011 rom_data_i  in  4  ROM read data, valid the cycle after rom_cen_o.
REQ-012 pix_valid_o / pix_ready_i  out/in  1  pixel stream handshake.
REQ-013 pix_data_o  out  4  pixel value.
REQ-014 pix_sof_o, pix_eol_o, pix_eof_o  out  1 each  first pixel of frame, last pixel of line, last pixel of frame; qualified by pix_valid_o.
REQ-015 busy_o  out  1  high when not IDLE.
REQ-016 frame_idx_o  out  5  current frame index.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN.
REQ-018 IDLE->RUN on start_i; RUN->DRAIN after the last read of a frame pass once stop is pending; DRAIN->IDLE when no read is outstanding and the buffer is empty.
REQ-019 stop_i SHALL be latched as stop-pending, cleared on entry to IDLE; start_i in RUN or DRAIN is ignored.
REQ-020 In RUN, rom_cen_o SHALL be 1 iff (outstanding reads + buffered pixels) < 2; rom_cen_o=0 outside RUN.
REQ-021 Each accepted read (rom_cen_o=1) SHALL capture rom_data_i into a 2-entry skid FIFO exactly one cycle later, with its sof/eol/eof tags carried along.
REQ-022 A pixel transfers when pix_valid_o && pix_ready_i; pix_valid_o SHALL equal FIFO non-empty; data and tags SHALL hold stable while valid && !ready.
REQ-023 Address SHALL be frame_idx*FRAME_PIXELS + pix_cnt, kept as an incrementing base register (no multiplier).
REQ-024 pix_cnt wraps FRAME_PIXELS-1 -> 0 at the end of a pass; a pass counter increments and, at FRAME_REPEAT, frame_idx advances, wrapping NUM_FRAMES-1 -> 0.
REQ-025 eol tag set when pix_cnt mod LINE_PIXELS = LINE_PIXELS-1; sof when pix_cnt=0; eof when pix_cnt=FRAME_PIXELS-1.
REQ-026 Leaving RUN for IDLE SHALL reset pix_cnt and the pass counter to 0 but keep frame_idx, so a restart resumes at the next frame to be shown.
REQ-027 With continuous ready, steady-state throughput SHALL be one pixel per cycle; first pix_valid_o 2 cycles after start_i.

Reset
REQ-028 On rst_ni low: state=IDLE, all outputs 0, frame_idx=0, counters 0, FIFO empty, stop-pending cleared, asynchronously, including mid-frame.

Configuration
REQ-029 Macro DONUT_STREAMER_FRAME_REPEAT_EN defined: FRAME_REPEAT honoured. Undefined: pass counter absent; every frame shown once.

Structure
REQ-030 Package donut_pkg SHALL hold FSM state enum, pixel width (4), default FRAME_PIXELS/LINE_PIXELS/NUM_FRAMES constants.
REQ-031 Skid FIFO SHALL be sub-module donut_pix_skid (2 entries, 7-bit payload: data+3 tags).

Verification
REQ-032 Reset, start_i, ready=1 -> addresses 0,1,2... one per cycle; first valid at cycle 2 with sof=1; eol at pixels 319, 639; eof at pixel 70399.
REQ-033 FRAME_REPEAT=2, macro on -> frame 0 streamed twice (addresses 0..70399 twice), then base 70400; macro off -> base 70400 after one pass.
REQ-034 Random pix_ready_i (50%) -> output sequence equals ROM contents in order, no loss/duplication, rom_cen_o never drives >2 in flight.
REQ-035 Frame 29 end -> address wraps 2111999 -> 0, frame_idx_o 29 -> 0.
REQ-036 stop_i at pixel 1000 of frame 3 -> frame 3 completes (eof seen), busy_o falls after drain; next start_i begins at frame 4 address 281600.
REQ-037 rst_ni low mid-frame with ready=0 and FIFO full -> all outputs 0 immediately; no stale pixel after release.

Source files
------------

// File: rtl/donut_pkg.sv
// Shared types and defaults for the donut frame streamer: FSM state, pixel
// width, the 7-bit skid payload and default frame geometry.
package donut_pkg;

  localparam int PIX_W     = 4;
  localparam int TAG_W     = 3;
  localparam int PAYLOAD_W = PIX_W + TAG_W;

  localparam int DEF_FRAME_PIXELS = 70400;
  localparam int DEF_LINE_PIXELS  = 320;
  localparam int DEF_NUM_FRAMES   = 30;
  localparam int DEF_FRAME_REPEAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } donut_state_e;

  // Field order fixes the packed layout {sof, eol, eof, data}.
  typedef struct packed {
    logic             sof;
    logic             eol;
    logic             eof;
    logic [PIX_W-1:0] data;
  } pix_word_t;

endpackage

// File: rtl/donut_frame_streamer_if.sv
// ROM read port and pixel stream of the donut frame streamer.
// Handshake: a pixel moves on a clock edge where pix_valid_o && pix_ready_i;
// while valid is high and ready low, data and tags hold stable and valid stays up.
interface donut_frame_streamer_if;

  logic                       rom_cen_o;
  logic [31:0]                rom_addr_o;
  logic [donut_pkg::PIX_W-1:0] rom_data_i;

  logic                       pix_valid_o;
  logic                       pix_ready_i;
  logic [donut_pkg::PIX_W-1:0] pix_data_o;
  logic                       pix_sof_o;
  logic                       pix_eol_o;
  logic                       pix_eof_o;

  modport master (
    output rom_cen_o, rom_addr_o,
    input  rom_data_i,
    output pix_valid_o, pix_data_o, pix_sof_o, pix_eol_o, pix_eof_o,
    input  pix_ready_i
  );

  modport slave (
    input  rom_cen_o, rom_addr_o,
    output rom_data_i,
    input  pix_valid_o, pix_data_o, pix_sof_o, pix_eol_o, pix_eof_o,
    output pix_ready_i
  );

endinterface

// File: rtl/donut_pix_skid.sv
// Two-entry skid FIFO holding tagged pixels between the ROM and the stream.
// The head word reads as zero while the FIFO is empty.
module donut_pix_skid
  import donut_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      wr_en_i,
  input  pix_word_t wr_word_i,
  input  logic      rd_en_i,
  output pix_word_t rd_word_o,
  output logic [1:0] count_o
);

  pix_word_t  mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push;
  logic       pop;

  assign pop  = rd_en_i && (count_q != 2'd0);
  assign push = wr_en_i && ((count_q != 2'd2) || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_word_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rd_word_o = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

endmodule

// File: rtl/donut_frame_streamer.sv
// Streams stored donut animation frames from ROM as a tagged pixel stream.
// Define DONUT_STREAMER_FRAME_REPEAT_EN to show each frame FRAME_REPEAT times.
module donut_frame_streamer
  import donut_pkg::*;
#(
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int LINE_PIXELS  = DEF_LINE_PIXELS,
  parameter int NUM_FRAMES   = DEF_NUM_FRAMES,
  parameter int FRAME_REPEAT = DEF_FRAME_REPEAT
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          stop_i,
  donut_frame_streamer_if.master        bus,
  output logic                          busy_o,
  output logic [4:0]                    frame_idx_o,
  output donut_state_e                  state_o
);

  localparam int COL_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;

  if ((FRAME_PIXELS % LINE_PIXELS) != 0 || FRAME_REPEAT < 1 || NUM_FRAMES > 32) begin : g_bad_params
    $error("donut_frame_streamer: inconsistent frame geometry parameters");
  end

  donut_state_e     state_q;
  logic             stop_pend_q;
  logic             rd_pend_q;
  logic [2:0]       tag_q;
  logic [31:0]      pix_cnt_q;
  logic [COL_W-1:0] col_q;
  logic [31:0]      base_q;
  logic [4:0]       frame_q;

  logic       cen;
  logic       pop;
  logic       last_pix;
  logic       adv;
  logic       drain_done;
  logic [1:0] fifo_cnt;
  pix_word_t  wr_word;
  pix_word_t  rd_word;

  assign pop      = bus.pix_valid_o && bus.pix_ready_i;
  assign last_pix = (pix_cnt_q == 32'(FRAME_PIXELS - 1));
  // Buffered pixels are counted after this cycle's pop so a drained slot
  // can be refilled in the same cycle, giving one pixel per clock.
  assign cen = (state_q == ST_RUN) &&
               (({1'b0, rd_pend_q} + fifo_cnt - {1'b0, pop}) < 2'd2);
  assign drain_done = (state_q == ST_DRAIN) && !rd_pend_q && (fifo_cnt == 2'd0);

`ifdef DONUT_STREAMER_FRAME_REPEAT_EN
  logic [15:0] pass_q;
  assign adv = (pass_q == 16'(FRAME_REPEAT - 1));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pass_q <= '0;
    end else if (drain_done) begin
      pass_q <= '0;
    end else if (cen && last_pix) begin
      pass_q <= adv ? '0 : pass_q + 16'd1;
    end
  end
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      tag_q       <= '0;
      pix_cnt_q   <= '0;
      col_q       <= '0;
      base_q      <= '0;
      frame_q     <= '0;
    end else begin
      rd_pend_q <= cen;
      if (cen) begin
        tag_q <= {pix_cnt_q == 32'd0, col_q == COL_W'(LINE_PIXELS - 1), last_pix};
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (stop_i) stop_pend_q <= 1'b1;
          if (cen) begin
            if (last_pix) begin
              pix_cnt_q <= '0;
              col_q     <= '0;
              if (adv) begin
                if (frame_q == 5'(NUM_FRAMES - 1)) begin
                  frame_q <= '0;
                  base_q  <= '0;
                end else begin
                  frame_q <= frame_q + 5'd1;
                  base_q  <= base_q + 32'(FRAME_PIXELS);
                end
              end
              if (stop_pend_q || stop_i) state_q <= ST_DRAIN;
            end else begin
              pix_cnt_q <= pix_cnt_q + 32'd1;
              col_q     <= (col_q == COL_W'(LINE_PIXELS - 1)) ? '0 : col_q + COL_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
            pix_cnt_q   <= '0;
            col_q       <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_word = {tag_q, bus.rom_data_i};

  donut_pix_skid u_skid (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (rd_pend_q),
    .wr_word_i (wr_word),
    .rd_en_i   (bus.pix_ready_i),
    .rd_word_o (rd_word),
    .count_o   (fifo_cnt)
  );

  assign bus.rom_cen_o   = cen;
  assign bus.rom_addr_o  = base_q + pix_cnt_q;
  assign bus.pix_valid_o = (fifo_cnt != 2'd0);
  assign bus.pix_data_o  = rd_word.data;
  assign bus.pix_sof_o   = rd_word.sof;
  assign bus.pix_eol_o   = rd_word.eol;
  assign bus.pix_eof_o   = rd_word.eof;

  assign busy_o      = (state_q != ST_IDLE);
  assign frame_idx_o = frame_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_donut_frame_streamer.sv
// Directed bench for donut_frame_streamer on a shrunken geometry
// (16-pixel frames, 4-pixel lines, 4 frames) with a scoreboard of ROM reads.
module tb_donut_frame_streamer;
  import donut_pkg::*;

  localparam int FP  = 16;
  localparam int LP  = 4;
  localparam int NF  = 4;
  localparam int REP = 2;
`ifdef DONUT_STREAMER_FRAME_REPEAT_EN
  localparam int PASSES = REP;
`else
  localparam int PASSES = 1;
`endif
  localparam int W = PAYLOAD_W;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic         busy;
  logic [4:0]   frame_idx;
  donut_state_e state;

  always #5 clk = ~clk;

  donut_frame_streamer_if bus ();

  donut_frame_streamer #(
    .FRAME_PIXELS (FP),
    .LINE_PIXELS  (LP),
    .NUM_FRAMES   (NF),
    .FRAME_REPEAT (REP)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .stop_i      (stop),
    .bus         (bus),
    .busy_o      (busy),
    .frame_idx_o (frame_idx),
    .state_o     (state)
  );

  int total = 0;
  int bad   = 0;
  int rd_n  = 0;
  int px_n  = 0;
  int seg_frame = 0;
  bit mon_en = 1'b0;
  logic last_eof = 1'b0;
  logic [W-1:0] exp_q [$];

  function automatic logic [3:0] rom_f(input logic [31:0] a);
    return a[3:0] + a[7:4] + 4'd5;
  endfunction

  function automatic logic [31:0] exp_addr(input int n);
    int fr;
    fr = (seg_frame + (n / FP) / PASSES) % NF;
    return 32'(fr * FP + n % FP);
  endfunction

  function automatic logic [W-1:0] exp_word(input logic [31:0] a);
    int p;
    p = int'(a) % FP;
    return {p == 0, (p % LP) == LP - 1, p == FP - 1, rom_f(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ROM model: data valid the cycle after an accepted read
  always @(posedge clk) begin
    if (bus.rom_cen_o) bus.rom_data_i <= rom_f(bus.rom_addr_o);
  end

  // scoreboard: reads push expected words, transfers pop and compare
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en && rst_n) begin
      if (bus.rom_cen_o) begin
        check("rd_addr", bus.rom_addr_o, exp_addr(rd_n));
        exp_q.push_back(exp_word(exp_addr(rd_n)));
        rd_n++;
      end
      if (bus.pix_valid_o && bus.pix_ready_i) begin
        check("pix_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pix_word",
                {25'd0, bus.pix_sof_o, bus.pix_eol_o, bus.pix_eof_o, bus.pix_data_o},
                {25'd0, e});
        end
        last_eof = bus.pix_eof_o;
        px_n++;
      end
      check("in_flight_le2", 32'((rd_n - px_n) <= 2), 32'd1);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_px(input int target, input int budget);
    int n;
    n = 0;
    while (px_n < target && n < budget) begin
      tick();
      n++;
    end
    check("wait_px_timeout", 32'(px_n >= target), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cen"},   32'(bus.rom_cen_o), 32'd0);
    check({tag, "_addr"},  bus.rom_addr_o, 32'd0);
    check({tag, "_valid"}, 32'(bus.pix_valid_o), 32'd0);
    check({tag, "_data"},  32'(bus.pix_data_o), 32'd0);
    check({tag, "_tags"},  32'({bus.pix_sof_o, bus.pix_eol_o, bus.pix_eof_o}), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_frame"}, 32'(frame_idx), 32'd0);
    check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
  endtask

  initial begin
    int px0;
    int n;
    int exp_fr;
    bus.pix_ready_i = 1'b0;

    // reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // start with continuous ready: latency and first pixel
    bus.pix_ready_i = 1'b1;
    seg_frame = 0;
    mon_en = 1'b1;
    pulse_start();
    @(negedge clk);
    check("lat0_busy",  32'(busy), 32'd1);
    check("lat0_cen",   32'(bus.rom_cen_o), 32'd1);
    check("lat0_addr",  bus.rom_addr_o, 32'd0);
    check("lat0_valid", 32'(bus.pix_valid_o), 32'd0);
    @(negedge clk);
    check("lat1_valid", 32'(bus.pix_valid_o), 32'd0);
    check("lat1_addr",  bus.rom_addr_o, 32'd1);
    @(negedge clk);
    check("lat2_valid", 32'(bus.pix_valid_o), 32'd1);
    check("lat2_sof",   32'(bus.pix_sof_o), 32'd1);
    check("lat2_data",  32'(bus.pix_data_o), 32'd5);
    tick();
    px0 = px_n;
    repeat (10) tick();
    check("throughput", 32'(px_n - px0), 32'd10);

    // start while running is ignored
    pulse_start();
    check("start_in_run_state", 32'(state), 32'(ST_RUN));

    // run past the last frame: frame index and addresses wrap to 0
    wait_px(NF * PASSES * FP + 2, 2000);
    check("wrap_frame_idx", 32'(frame_idx), 32'd0);

    // random backpressure
    repeat (300) begin
      tick();
      bus.pix_ready_i = 1'($urandom_range(0, 1));
    end
    bus.pix_ready_i = 1'b1;

    // stop mid-frame: current pass finishes, then drain to idle
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check("stop_busy_timeout", 32'(busy), 32'd0);
    check("stop_frame_boundary", 32'(px_n % FP), 32'd0);
    check("stop_last_eof", 32'(last_eof), 32'd1);
    check("stop_no_loss", 32'(rd_n - px_n), 32'd0);
    check("stop_q_empty", 32'(exp_q.size()), 32'd0);
    check("stop_cen", 32'(bus.rom_cen_o), 32'd0);
    check("stop_valid", 32'(bus.pix_valid_o), 32'd0);
    exp_fr = (seg_frame + (px_n / FP) / PASSES) % NF;
    check("stop_frame_idx", 32'(frame_idx), 32'(exp_fr));
    repeat (3) tick();
    check("idle_stays", 32'(busy), 32'd0);

    // restart resumes at the next frame, pixel 0
    seg_frame = exp_fr;
    rd_n = 0;
    px_n = 0;
    pulse_start();
    wait_px(20, 200);

    // reset mid-frame with the FIFO full and the stream stalled
    bus.pix_ready_i = 1'b0;
    repeat (4) tick();
    check("stall_valid", 32'(bus.pix_valid_o), 32'd1);
    check("stall_cen", 32'(bus.rom_cen_o), 32'd0);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    bus.pix_ready_i = 1'b1;
    repeat (3) tick();
    check("post_rst_valid", 32'(bus.pix_valid_o), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // fresh start after reset begins at frame 0
    exp_q.delete();
    rd_n = 0;
    px_n = 0;
    seg_frame = 0;
    mon_en = 1'b1;
    pulse_start();
    wait_px(10, 200);
    check("post_rst_frame", 32'(frame_idx), 32'd0);

    // final report
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
